// File: rtl/twos_complement.sv
// Registered two's-complement negator with optional one's-complement mode and status flags.
// Define TWOS_COMPLEMENT_SAT_EN to saturate the most-negative operand to the largest positive value.
module twos_complement #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             in_valid,
  input  logic             ones_mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = ~MOST_NEG;

  logic [WIDTH-1:0] raw_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             zero_c;

  // Negate or invert, flag the one operand whose negation is not representable.
  always_comb begin
    raw_c  = ~inp + WIDTH'(1);
    ovf_c  = 1'b0;
    if (ones_mode) begin
      raw_c = ~inp;
    end else begin
      ovf_c = (inp == MOST_NEG);
    end
    res_c = raw_c;
`ifdef TWOS_COMPLEMENT_SAT_EN
    if (ovf_c) begin
      res_c = MAX_POS;
    end
`endif
    zero_c = (res_c == '0);
  end

  // Single output stage; result and flags hold while no operand is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= res_c;
        ovf  <= ovf_c;
        zero <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_twos_complement.sv
// Directed self-checking bench for twos_complement at WIDTH=4.
module tb_twos_complement;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] inp;
  logic             in_valid;
  logic             ones_mode;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             ovf;
  logic             zero;

  int errors = 0;
  int checks = 0;

  twos_complement #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .in_valid  (in_valid),
    .ones_mode (ones_mode),
    .out       (out),
    .out_valid (out_valid),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e_out, input int e_vld,
                           input int e_ovf, input int e_zero);
    check({tag, ".out"},       32'(out),       32'(e_out));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    check({tag, ".ovf"},       32'(ovf),       32'(e_ovf));
    check({tag, ".zero"},      32'(zero),      32'(e_zero));
  endtask

  int most_neg_out;

  initial begin
`ifdef TWOS_COMPLEMENT_SAT_EN
    most_neg_out = 7;
`else
    most_neg_out = 8;
`endif
    rst = 1'b1; in_valid = 1'b1; inp = 4'h5; ones_mode = 1'b0;

    // Reset held two cycles with a valid operand present
    tick(); check_all("rst1", 0, 0, 0, 0);
    tick(); check_all("rst2", 0, 0, 0, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick(); check_all("post_rst", 0, 0, 0, 0);

    // Exhaustive two's-complement sweep, one operand per cycle
    for (int i = 0; i < 16; i++) begin
      inp = 4'(i); in_valid = 1'b1; ones_mode = 1'b0;
      tick();
      if (i == 8)
        check_all($sformatf("sweep%0d", i), most_neg_out, 1, 1, 0);
      else
        check_all($sformatf("sweep%0d", i), (16 - i) % 16, 1, 0, (i == 0) ? 1 : 0);
    end

    // One's-complement mode
    ones_mode = 1'b1;
    inp = 4'b0101; tick(); check_all("ones_5", 10, 1, 0, 0);
    inp = 4'hF;    tick(); check_all("ones_F", 0, 1, 0, 1);
    inp = 4'h8;    tick(); check_all("ones_8", 7, 1, 0, 0);
    inp = 4'h0;    tick(); check_all("ones_0", 15, 1, 0, 0);

    // Hold across a gap of invalid cycles
    ones_mode = 1'b0;
    inp = 4'd2; tick(); check_all("gap_in", 14, 1, 0, 0);
    in_valid = 1'b0; inp = 4'd9; ones_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_all($sformatf("gap%0d", i), 14, 0, 0, 0);
    end
    in_valid = 1'b1; ones_mode = 1'b0; inp = 4'd6;
    tick(); check_all("gap_out", 10, 1, 0, 0);

    // Flags hold while idle after an overflow result
    inp = 4'd8; tick(); check_all("ovf_in", most_neg_out, 1, 1, 0);
    in_valid = 1'b0; inp = 4'd0;
    tick(); check_all("ovf_hold", most_neg_out, 0, 1, 0);

    // Reset mid-stream drops the operand on the reset edge
    in_valid = 1'b1; inp = 4'd3; tick(); check_all("mid_pre", 13, 1, 0, 0);
    rst = 1'b1; inp = 4'd4; tick(); check_all("mid_rst", 0, 0, 0, 0);
    rst = 1'b0; in_valid = 1'b0; tick(); check_all("mid_post", 0, 0, 0, 0);
    in_valid = 1'b1; inp = 4'd1; tick(); check_all("mid_resume", 15, 1, 0, 0);
    in_valid = 1'b0; tick(); check_all("mid_idle", 15, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
